// File: rtl/pre_if_stage_pkg.sv
// Shared widths, bus layouts and state encoding for the pre-IF fetch stage.
// Bus structs mirror the packed concatenation order used on the stage ports.
package pre_if_stage_pkg;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned ID_TO_IF_WD     = 34;
  localparam int unsigned MEM_TO_IF_WD    = 2;
  localparam int unsigned CSR_TO_IF_WD    = 64;
  localparam int unsigned PRE_IF_TO_IF_WD = 33;

  typedef enum logic {
    PIF_IDLE = 1'b0,
    PIF_REQ  = 1'b1
  } pif_state_e;

  typedef struct packed {
    logic            br_stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
  } id_to_if_t;

  typedef struct packed {
    logic excp;
    logic ertn;
  } mem_to_if_t;

  typedef struct packed {
    logic [PC_W-1:0] eentry;
    logic [PC_W-1:0] era;
  } csr_to_if_t;

  typedef struct packed {
    logic            discard;
    logic [PC_W-1:0] pc;
  } pre_if_to_if_t;

  // Exception beats ertn, which beats a taken branch.
  function automatic logic [PC_W-1:0] pick_redirect_pc(
    input logic            excp,
    input logic            ertn,
    input logic [PC_W-1:0] eentry,
    input logic [PC_W-1:0] era,
    input logic [PC_W-1:0] br_target
  );
    if (excp) return eentry;
    if (ertn) return era;
    return br_target;
  endfunction

endpackage

// File: rtl/pre_if_redirect_buf.sv
// Holds one redirect that could not be launched immediately.
// A branch never displaces a buffered exception/ertn target; exception/ertn always replace.
module pre_if_redirect_buf
  import pre_if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr_i,
  input  logic            wr_i,
  input  logic            wr_exc_i,
  input  logic [PC_W-1:0] wr_target_i,
  output logic            rd_valid_o,
  output logic [PC_W-1:0] rd_target_o
);

  logic            valid_q, valid_d;
  logic            exc_q, exc_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            accept;

  assign accept = wr_i & (wr_exc_i | ~(valid_q & exc_q));

  always_comb begin
    valid_d  = valid_q;
    exc_d    = exc_q;
    target_d = target_q;
    if (clr_i) begin
      valid_d = 1'b0;
      exc_d   = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      exc_d    = wr_exc_i;
      target_d = wr_target_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      exc_q    <= exc_d;
      target_q <= target_d;
    end
  end

  assign rd_valid_o  = valid_q;
  assign rd_target_o = target_q;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC and drives the SRAM-like instruction request port.
// Redirects seen while a request is outstanding are buffered and tag that fetch as discard.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       if_allowin,
  input  logic [ID_TO_IF_WD-1:0]     id_to_if_bus,
  input  logic [MEM_TO_IF_WD-1:0]    mem_to_if_bus,
  input  logic [CSR_TO_IF_WD-1:0]    csr_to_if_bus,
  output logic                       pre_if_to_if_valid,
  output logic [PRE_IF_TO_IF_WD-1:0] pre_if_to_if_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok
);

  id_to_if_t     id_bus;
  mem_to_if_t    mem_bus;
  csr_to_if_t    csr_bus;
  pre_if_to_if_t out_bus;

  assign id_bus  = id_to_if_bus;
  assign mem_bus = mem_to_if_bus;
  assign csr_bus = csr_to_if_bus;

  pif_state_e      state_q;
  logic [PC_W-1:0] req_addr_q;
  logic [PC_W-1:0] last_pc_q;
  logic            stale_q;

  logic            exc_redirect;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            launch;
  logic            req;
  logic            handshake;
  logic            consume;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] nextpc_d;
  logic            rd_valid;
  logic [PC_W-1:0] rd_target;

  assign exc_redirect = mem_bus.excp | mem_bus.ertn;
  assign redirect     = exc_redirect | id_bus.br_taken;
  assign redirect_pc  = pick_redirect_pc(mem_bus.excp, mem_bus.ertn, csr_bus.eentry,
                                         csr_bus.era, id_bus.br_target);

  assign launch    = if_allowin & ~id_bus.br_stall;
  assign req       = (state_q == PIF_REQ) & if_allowin;
  assign handshake = req & inst_sram_addr_ok;
  assign consume   = launch & ((state_q == PIF_IDLE) | handshake);

  // Back-to-back issue: the successor is taken from the fetch accepted this cycle,
  // which only reaches last_pc_q on the next edge.
  assign seq_pc = (handshake ? req_addr_q : last_pc_q) + 32'd4;

  always_comb begin
    nextpc_d = seq_pc;
    if (mem_bus.excp)        nextpc_d = csr_bus.eentry;
    else if (mem_bus.ertn)   nextpc_d = csr_bus.era;
    else if (rd_valid)       nextpc_d = rd_target;
    else if (id_bus.br_taken) nextpc_d = id_bus.br_target;
  end

  pre_if_redirect_buf u_rd_buf (
    .clk         (clk),
    .resetn      (resetn),
    .clr_i       (consume),
    .wr_i        (redirect & ~consume),
    .wr_exc_i    (exc_redirect),
    .wr_target_i (redirect_pc),
    .rd_valid_o  (rd_valid),
    .rd_target_o (rd_target)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= PIF_IDLE;
      req_addr_q <= '0;
      last_pc_q  <= RESET_PC - 32'd4;
      stale_q    <= 1'b0;
    end else begin
      case (state_q)
        PIF_IDLE: begin
          if (launch) begin
            req_addr_q <= nextpc_d;
            state_q    <= PIF_REQ;
          end
        end
        PIF_REQ: begin
          if (handshake) begin
            last_pc_q <= req_addr_q;
            stale_q   <= 1'b0;
            if (launch) req_addr_q <= nextpc_d;
            else        state_q    <= PIF_IDLE;
          end else if (redirect) begin
            stale_q <= 1'b1;
          end
        end
        default: state_q <= PIF_IDLE;
      endcase
    end
  end

  assign out_bus.discard = stale_q | redirect;
  assign out_bus.pc      = req_addr_q;

  assign pre_if_to_if_valid = handshake;
  assign pre_if_to_if_bus   = handshake ? out_bus : '0;

  assign inst_sram_req   = req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = '0;
  assign inst_sram_addr  = req_addr_q;
  assign inst_sram_wdata = '0;

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level fetch model.
module tb_pre_if_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_allowin;
  logic [33:0] id_to_if_bus;
  logic [1:0]  mem_to_if_bus;
  logic [63:0] csr_to_if_bus;
  logic        pre_if_to_if_valid;
  logic [32:0] pre_if_to_if_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;

  always #5 clk = ~clk;

  pre_if_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .if_allowin         (if_allowin),
    .id_to_if_bus       (id_to_if_bus),
    .mem_to_if_bus      (mem_to_if_bus),
    .csr_to_if_bus      (csr_to_if_bus),
    .pre_if_to_if_valid (pre_if_to_if_valid),
    .pre_if_to_if_bus   (pre_if_to_if_bus),
    .inst_sram_req      (inst_sram_req),
    .inst_sram_wr       (inst_sram_wr),
    .inst_sram_size     (inst_sram_size),
    .inst_sram_wstrb    (inst_sram_wstrb),
    .inst_sram_addr     (inst_sram_addr),
    .inst_sram_wdata    (inst_sram_wdata),
    .inst_sram_addr_ok  (inst_sram_addr_ok)
  );

  int checks   = 0;
  int failures = 0;

  // Fetch model: an outstanding request (if any), the last accepted PC,
  // one pending redirect, and whether the outstanding fetch is on a wrong path.
  logic        m_busy;
  logic [31:0] m_addr;
  logic [31:0] m_last;
  logic        m_pend;
  logic        m_pend_exc;
  logic [31:0] m_pend_pc;
  logic        m_wrong;

  // Values sampled on the last negedge, for literal checks.
  logic        s_req, s_valid, s_disc;
  logic [31:0] s_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_addr     = 32'h0;
    m_last     = 32'h1c00_0000 - 32'd4;
    m_pend     = 1'b0;
    m_pend_exc = 1'b0;
    m_pend_pc  = 32'h0;
    m_wrong    = 1'b0;
  endtask

  task automatic remember(input logic ex, input logic er, input logic bt,
                          input logic [31:0] een, input logic [31:0] ea, input logic [31:0] tgt);
    if (ex || er) begin
      m_pend = 1'b1; m_pend_exc = 1'b1; m_pend_pc = ex ? een : ea;
    end else if (bt && !(m_pend && m_pend_exc)) begin
      m_pend = 1'b1; m_pend_exc = 1'b0; m_pend_pc = tgt;
    end
  endtask

  task automatic step(input logic al, input logic st, input logic bt, input logic [31:0] tgt,
                      input logic ex, input logic er, input logic [31:0] een,
                      input logic [31:0] ea, input logic ok);
    logic        e_req, e_val, redir, go;
    logic [32:0] e_bus;
    logic [31:0] nxt;
    if_allowin        = al;
    id_to_if_bus      = {st, bt, tgt};
    mem_to_if_bus     = {ex, er};
    csr_to_if_bus     = {een, ea};
    inst_sram_addr_ok = ok;
    @(negedge clk);
    s_req   = inst_sram_req;
    s_valid = pre_if_to_if_valid;
    s_disc  = pre_if_to_if_bus[32];
    s_addr  = inst_sram_addr;
    redir   = ex | er | bt;
    go      = al & ~st;
    e_req   = m_busy & al;
    e_val   = e_req & ok;
    e_bus   = e_val ? {m_wrong | redir, m_addr} : 33'h0;
    chk("req", {63'h0, inst_sram_req}, {63'h0, e_req});
    chk("addr", {32'h0, inst_sram_addr}, {32'h0, m_addr});
    chk("valid", {63'h0, pre_if_to_if_valid}, {63'h0, e_val});
    chk("bus", {31'h0, pre_if_to_if_bus}, {31'h0, e_bus});
    chk("const", {25'h0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
        {25'h0, 1'b0, 2'b10, 4'h0, 32'h0});
    if (e_val) m_last = m_addr;
    if (ex)          nxt = een;
    else if (er)     nxt = ea;
    else if (m_pend) nxt = m_pend_pc;
    else if (bt)     nxt = tgt;
    else             nxt = m_last + 32'd4;
    if (!m_busy) begin
      if (go) begin m_busy = 1'b1; m_addr = nxt; m_pend = 1'b0; m_pend_exc = 1'b0; end
      else if (redir) remember(ex, er, bt, een, ea, tgt);
    end else if (e_val) begin
      m_wrong = 1'b0;
      if (go) begin m_addr = nxt; m_pend = 1'b0; m_pend_exc = 1'b0; end
      else begin
        m_busy = 1'b0;
        if (redir) remember(ex, er, bt, een, ea, tgt);
      end
    end else if (redir) begin
      m_wrong = 1'b1;
      remember(ex, er, bt, een, ea, tgt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic al, input logic ok);
    step(al, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
  endtask

  task automatic br(input logic [31:0] tgt, input logic ok);
    step(1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 32'h0, 32'h0, ok);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    chk("rst_req", {63'h0, inst_sram_req}, 64'h0);
    chk("rst_addr", {32'h0, inst_sram_addr}, 64'h0);
    chk("rst_valid", {63'h0, pre_if_to_if_valid}, 64'h0);
    chk("rst_bus", {31'h0, pre_if_to_if_bus}, 64'h0);
    chk("rst_size", {62'h0, inst_sram_size}, 64'h2);
    if_allowin        = 1'b0;
    id_to_if_bus      = '0;
    mem_to_if_bus     = '0;
    csr_to_if_bus     = '0;
    inst_sram_addr_ok = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_allowin = 1'b1;
    id_to_if_bus = '0; mem_to_if_bus = '0; csr_to_if_bus = '0; inst_sram_addr_ok = 1'b0;
    do_reset();

    // Sequential start, then a branch while the request waits for addr_ok.
    run(1, 1);                 chk("d_idle_req", {63'h0, s_req}, 64'h0);
    run(1, 1);                 chk("d_pc0", {32'h0, s_addr}, 64'h1c00_0000);
                               chk("d_pc0_disc", {62'h0, s_valid, s_disc}, 64'h2);
    run(1, 0);                 chk("d_pc1_wait", {31'h0, s_req, s_valid, s_addr}, {31'h0, 2'b10, 32'h1c00_0004});
    run(1, 0);
    br(32'h1c00_0100, 0);      chk("d_pc1_hold", {32'h0, s_addr}, 64'h1c00_0004);
    run(1, 1);                 chk("d_pc1_discard", {31'h0, s_valid, s_disc, s_addr}, {31'h0, 2'b11, 32'h1c00_0004});
    run(1, 1);                 chk("d_br_target", {31'h0, s_valid, s_disc, s_addr}, {31'h0, 2'b10, 32'h1c00_0100});

    // Redirect on the handshake cycle, then buffered br overwritten by excp.
    do_reset();
    run(1, 1); run(1, 1); run(1, 1);
    br(32'h1c00_0040, 1);      chk("d_hs_redirect", {31'h0, s_valid, s_disc, s_addr}, {31'h0, 2'b11, 32'h1c00_0008});
    run(1, 1);                 chk("d_hs_target", {31'h0, s_valid, s_disc, s_addr}, {31'h0, 2'b10, 32'h1c00_0040});
    br(32'h1c00_0200, 0);
    step(1, 0, 0, 32'h0, 1, 0, 32'h1c00_8000, 32'h0, 0);
    br(32'h1c00_0300, 0);
    run(1, 1);                 chk("d_buf_discard", {31'h0, s_valid, s_disc, s_addr}, {31'h0, 2'b11, 32'h1c00_0044});
    run(1, 1);                 chk("d_excp_wins", {32'h0, s_addr}, 64'h1c00_8000);

    // br_stall drops into IDLE and holds off new requests.
    step(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    step(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1); chk("d_stall_req", {63'h0, s_req}, 64'h0);
    step(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    br(32'h1c00_0500, 1);      chk("d_stall_req2", {63'h0, s_req}, 64'h0);
    run(1, 1);                 chk("d_stall_br", {32'h0, s_addr}, 64'h1c00_0500);

    // Withdrawn request, then reset in the middle of REQ.
    run(0, 1);                 chk("d_withdraw", {31'h0, s_req, s_valid, s_addr}, {31'h0, 2'b00, 32'h1c00_0504});
    run(0, 1);
    if_allowin = 1'b1;
    do_reset();
    run(1, 1);
    run(1, 1);                 chk("d_restart", {32'h0, s_addr}, 64'h1c00_0000);

    // excp and br together, then sequential wrap past the top of the address space.
    step(1, 0, 1, 32'h1c00_00f0, 1, 0, 32'hffff_fff8, 32'h0, 1);
    run(1, 1);                 chk("d_wrap0", {32'h0, s_addr}, 64'hffff_fff8);
    run(1, 1);
    run(1, 1);                 chk("d_wrap2", {32'h0, s_addr}, 64'h0);
    step(1, 0, 0, 32'h0, 0, 1, 32'h0, 32'h1c00_0ab0, 1);
    run(1, 1);                 chk("d_ertn", {32'h0, s_addr}, 64'h1c00_0ab0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
           $urandom & 32'hffff_fffc, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
           $urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc, $urandom_range(0, 9) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
